// File: rtl/rr_stream_mux.sv
// rr_stream_mux: registered N-to-1 stream mux with round-robin or fixed-select arbitration
module rr_stream_mux #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          fixed_sel,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);
    logic [SEL_W-1:0]    last_grant;
    logic [SEL_W-1:0]    grant;
    logic [SEL_W-1:0]    idx;
    logic [CHANNELS-1:0] elig;
    logic                grant_valid;
    logic                can_accept;
    logic                take;
    always_comb begin
        elig = mode ? (in_valid & (CHANNELS'(1) << fixed_sel)) : in_valid;
        grant_valid = 1'b0;
        grant = '0;
        idx = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = last_grant + SEL_W'(k);
            if (!grant_valid && elig[idx]) begin
                grant_valid = 1'b1;
                grant = idx;
            end
        end
    end
    assign can_accept = !out_valid || out_ready;
    assign take       = !reset && can_accept && grant_valid;
    assign in_ready   = take ? (CHANNELS'(1) << grant) : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            last_grant <= '1;
        end else if (take) begin
            out_valid  <= 1'b1;
            out_data   <= in_data[int'(grant)*WIDTH +: WIDTH];
            out_chan   <= grant;
            last_grant <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed self-checking bench for rr_stream_mux (4 channels x 8 bits)
module tb_rr_stream_mux;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  fixed_sel;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_ready;
    int          n_tests = 0;
    int          n_fail = 0;

    rr_stream_mux #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mode(mode), .fixed_sel(fixed_sel),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"}, 32'(out_data), 32'(d));
        check({tag, ".chan"}, 32'(out_chan), 32'(c));
    endtask

    initial begin
        logic [7:0] rr_data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        logic [1:0] sp_chan [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        reset = 1'b1;
        in_valid = 4'hF;
        in_data = 32'h44332211;
        mode = 1'b0;
        fixed_sel = 2'd0;
        out_ready = 1'b1;
        // reset held two cycles with every channel valid
        step();
        step();
        check_out("reset", 1'b0, 8'h00, 2'd0);
        check("reset.in_ready", 32'(in_ready), 32'h0);
        reset = 1'b0;
        #1;
        check("release.in_ready", 32'(in_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            step();
            check_out($sformatf("rr%0d", k), 1'b1, rr_data[k], 2'(k % 4));
            check($sformatf("rr%0d.in_ready", k), 32'(in_ready), 32'(1 << ((k + 1) % 4)));
        end
        // bring last_grant to 3, then only channels 1 and 3
        in_valid = 4'b1000;
        step();
        check_out("sp_pre", 1'b1, 8'h44, 2'd3);
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            check_out($sformatf("sp%0d", k), 1'b1, sp_chan[k] == 2'd1 ? 8'h22 : 8'h44, sp_chan[k]);
        end
        in_valid = 4'b1000;
        #1;
        check("sp_self.in_ready", 32'(in_ready), 32'h8);
        step();
        check_out("sp_self", 1'b1, 8'h44, 2'd3);
        // backpressure with register full
        in_valid = 4'hF;
        out_ready = 1'b0;
        #1;
        check("bp.in_ready", 32'(in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_out($sformatf("bp%0d", k), 1'b1, 8'h44, 2'd3);
            check($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel.in_ready", 32'(in_ready), 32'h1);
        step();
        check_out("bp_fill", 1'b1, 8'h11, 2'd0);
        // fixed select on channel 2
        mode = 1'b1;
        fixed_sel = 2'd2;
        #1;
        check("fx.in_ready", 32'(in_ready), 32'h4);
        for (int k = 0; k < 3; k++) begin
            step();
            check_out($sformatf("fx%0d", k), 1'b1, 8'h33, 2'd2);
        end
        in_valid = 4'b1011;
        #1;
        check("fx_none.in_ready", 32'(in_ready), 32'h0);
        step();
        check_out("fx_drain", 1'b0, 8'h33, 2'd2);
        mode = 1'b0;
        #1;
        check("fx_back.in_ready", 32'(in_ready), 32'h8);
        step();
        check_out("fx_back", 1'b1, 8'h44, 2'd3);
        // reset while full and stalled
        in_valid = 4'hF;
        out_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_mid.in_ready", 32'(in_ready), 32'h0);
        step();
        check_out("rst_mid", 1'b0, 8'h00, 2'd0);
        check("rst_mid2.in_ready", 32'(in_ready), 32'h0);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_rel.in_ready", 32'(in_ready), 32'h1);
        step();
        check_out("rst_first", 1'b1, 8'h11, 2'd0);
        // drain with nothing valid: data and channel hold
        in_valid = 4'h0;
        step();
        check_out("drain_only", 1'b0, 8'h11, 2'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
